whirlpool_work_handler: RTL and testbench

- Initiator side of the iterative Whirlpool hash core interface: accepts a work unit (midstate, block template, target, nonce range) and sweeps the nonce through the range.
- For each nonce it inserts the nonce into the block, restarts the core, waits for the core's ready pulse and compares the hash against the target.
- Sits between the host work interface and one hash core instance; reports golden nonces and end-of-work.

---
 rtl/whirlpool_pkg.sv | 16 +
 rtl/whirlpool_nonce_insert.sv | 19 +
 rtl/whirlpool_work_handler.sv | 155 +++++++++++++++
 tb/tb_whirlpool_work_handler.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/whirlpool_pkg.sv
// Shared definitions for the Whirlpool work handler slice.
// CORE_LATENCY describes the attached core (start pulse to hash_ready
// pulse). The handler does not depend on it and always waits for the pulse.
package whirlpool_pkg;
  localparam int CORE_LATENCY = 20;
  localparam int NONCE_W      = 32;
  localparam int BLOCK_W      = 512;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    WAIT  = 3'd2,
    CHECK = 3'd3,
    DONE  = 3'd4
  } handler_state_t;
endpackage

// File: rtl/whirlpool_nonce_insert.sv
// Combinational field replace: writes a 32-bit nonce into a 512-bit block
// at bit offset NONCE_LSB. All other bits pass through unchanged.
//   block_in  : block template
//   nonce     : nonce to insert
//   block_out : template with the nonce field replaced
module whirlpool_nonce_insert
  import whirlpool_pkg::*;
#(
  parameter int NONCE_LSB = 0
) (
  input  logic [BLOCK_W-1:0] block_in,
  input  logic [NONCE_W-1:0] nonce,
  output logic [BLOCK_W-1:0] block_out
);
  always_comb begin
    block_out = block_in;
    block_out[NONCE_LSB +: NONCE_W] = nonce;
  end
endmodule

// File: rtl/whirlpool_work_handler.sv
// Initiator for one iterative Whirlpool hash core. Accepts a work unit
// (midstate, block template, target, inclusive nonce range), then for each
// nonce: restarts the core with the nonce inserted, waits for the core's
// ready pulse (with a watchdog), and compares the hash MSBs to the target.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   work_*/nonce_start/end   host work unit, taken when work_valid && work_ready
//   abort                    drop current work (ignored in IDLE)
//   core_rst/block/state     core restart pulse and its inputs
//   core_hash_ready/hash     core result, valid in the ready cycle only
//   golden_valid/nonce       pulse on a passing nonce; nonce is held
//   work_done, core_error    end-of-range and watchdog pulses
//   work_ready, busy         idle / not-idle status
// All outputs are registered. Pulses decided in a state show up the cycle
// after that state; core_rst/core_block/core_state are set on entry to LOAD.
module whirlpool_work_handler
  import whirlpool_pkg::*;
#(
  parameter int NONCE_LSB = 0,
  parameter int CMP_W     = 64,
  parameter int TIMEOUT   = 63
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               work_valid,
  output logic               work_ready,
  input  logic [BLOCK_W-1:0] work_midstate,
  input  logic [BLOCK_W-1:0] work_block,
  input  logic [CMP_W-1:0]   work_target,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  input  logic               abort,
  output logic               core_rst,
  output logic [BLOCK_W-1:0] core_block,
  output logic [BLOCK_W-1:0] core_state,
  input  logic               core_hash_ready,
  input  logic [BLOCK_W-1:0] core_hash,
  output logic               golden_valid,
  output logic [NONCE_W-1:0] golden_nonce,
  output logic               work_done,
  output logic               core_error,
  output logic               busy
);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  handler_state_t state, next;

  logic [BLOCK_W-1:0] blk_q, mid_q;
  logic [CMP_W-1:0]   tgt_q, hash_hi_q;
  logic [NONCE_W-1:0] end_q, nonce_q;
  logic [WD_W-1:0]    wdog;

  logic               abort_act, gold_hit, timeout, done_hit;
  logic [NONCE_W-1:0] ins_nonce;
  logic [BLOCK_W-1:0] ins_blk, ins_out;

  // The block loaded next comes straight from the host on the first nonce,
  // otherwise from the latched template with the incremented nonce.
  assign ins_nonce = (state == IDLE) ? nonce_start : nonce_q + 32'd1;
  assign ins_blk   = (state == IDLE) ? work_block  : blk_q;

  whirlpool_nonce_insert #(.NONCE_LSB(NONCE_LSB)) u_insert (
    .block_in  (ins_blk),
    .nonce     (ins_nonce),
    .block_out (ins_out)
  );

  always_comb begin
    next      = state;
    gold_hit  = 1'b0;
    timeout   = 1'b0;
    done_hit  = 1'b0;
    abort_act = abort && (state != IDLE);
    case (state)
      IDLE:  if (work_valid) next = LOAD;
      LOAD:  next = WAIT;
      WAIT: begin
        // A ready pulse in the last watchdog cycle still counts.
        if (core_hash_ready) next = CHECK;
        else if (wdog == WD_W'(TIMEOUT - 1)) begin
          timeout = 1'b1;
          next    = DONE;
        end
      end
      CHECK: begin
        gold_hit = (hash_hi_q <= tgt_q);
        next     = (nonce_q == end_q) ? DONE : LOAD;
      end
      DONE: begin
        done_hit = 1'b1;
        next     = IDLE;
      end
      default: next = IDLE;
    endcase
    // Abort wins over everything and swallows this cycle's pulses.
    if (abort_act) begin
      next     = IDLE;
      gold_hit = 1'b0;
      timeout  = 1'b0;
      done_hit = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      core_rst     <= 1'b1;
      core_block   <= '0;
      core_state   <= '0;
      golden_valid <= 1'b0;
      golden_nonce <= '0;
      work_done    <= 1'b0;
      core_error   <= 1'b0;
      work_ready   <= 1'b1;
      busy         <= 1'b0;
      blk_q        <= '0;
      mid_q        <= '0;
      tgt_q        <= '0;
      hash_hi_q    <= '0;
      end_q        <= '0;
      nonce_q      <= '0;
      wdog         <= '0;
    end else begin
      state        <= next;
      // Core stays parked in reset whenever the handler is idle.
      core_rst     <= (next == LOAD) || (next == IDLE);
      work_ready   <= (next == IDLE);
      busy         <= (next != IDLE);
      golden_valid <= gold_hit;
      work_done    <= done_hit;
      core_error   <= timeout;
      if (gold_hit) golden_nonce <= nonce_q;

      if (state == IDLE && work_valid) begin
        blk_q   <= work_block;
        mid_q   <= work_midstate;
        tgt_q   <= work_target;
        end_q   <= nonce_end;
        nonce_q <= nonce_start;
      end
      if (state == CHECK && next == LOAD) nonce_q <= nonce_q + 32'd1;

      if (next == LOAD) begin
        core_block <= ins_out;
        core_state <= (state == IDLE) ? work_midstate : mid_q;
      end

      if (state == LOAD)      wdog <= '0;
      else if (state == WAIT) wdog <= wdog + 1'b1;

      if (state == WAIT && core_hash_ready)
        hash_hi_q <= core_hash[BLOCK_W-1 -: CMP_W];
    end
  end
endmodule

// File: tb/tb_whirlpool_work_handler.sv
// Directed bench for whirlpool_work_handler with a behavioural core model
// that answers 20 cycles after the LOAD cycle.
module tb_whirlpool_work_handler;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         work_valid = 1'b0, abort = 1'b0;
  logic         work_ready, core_rst, golden_valid, work_done, core_error, busy;
  logic [511:0] work_midstate = '0, work_block = '0;
  logic [63:0]  work_target = '0;
  logic [31:0]  nonce_start = '0, nonce_end = '0;
  logic [511:0] core_block, core_state;
  logic         core_hash_ready = 1'b0;
  logic [511:0] core_hash = '0;
  logic [31:0]  golden_nonce;

  whirlpool_work_handler dut (
    .clk(clk), .rst(rst), .work_valid(work_valid), .work_ready(work_ready),
    .work_midstate(work_midstate), .work_block(work_block),
    .work_target(work_target), .nonce_start(nonce_start),
    .nonce_end(nonce_end), .abort(abort), .core_rst(core_rst),
    .core_block(core_block), .core_state(core_state),
    .core_hash_ready(core_hash_ready), .core_hash(core_hash),
    .golden_valid(golden_valid), .golden_nonce(golden_nonce),
    .work_done(work_done), .core_error(core_error), .busy(busy)
  );

  always #5 clk = ~clk;

  // model controls (written by the stimulus process only)
  logic [31:0] pass_n = '0;
  logic [63:0] hv_pass = '0, hv_fail = '0;
  logic        hang = 1'b0, stray = 1'b0;

  // monitor / core-model state (written by the monitor process only)
  int          cyc = 0;
  int          cnt = 0;
  logic        armed = 1'b0;
  logic [31:0] mnonce = '0;
  logic [31:0] ld_n[$];
  int          ld_c[$];
  logic [511:0] ld_blk = '0, ld_st = '0;
  int          gv_n = 0, gv_c = 0, wd_n = 0, wd_c = 0, ce_n = 0, ce_c = 0;
  logic [31:0] gv_nonce = '0;
  logic        wd_rdy = 1'b0;

  always @(posedge clk) begin
    cyc++;
    #1;
    core_hash_ready = 1'b0;
    if (core_rst) begin
      armed = 1'b1; cnt = 0; mnonce = core_block[31:0];
    end else if (armed && !hang) begin
      cnt++;
      if (cnt == 20) begin
        core_hash_ready = 1'b1;
        core_hash = {((mnonce == pass_n) ? hv_pass : hv_fail), 448'd0};
        armed = 1'b0;
      end
    end
    if (stray) begin
      core_hash_ready = 1'b1;
      core_hash = '0;
    end
    if (core_rst && busy) begin
      ld_n.push_back(core_block[31:0]); ld_c.push_back(cyc);
      ld_blk = core_block; ld_st = core_state;
    end
    if (golden_valid) begin gv_n++; gv_c = cyc; gv_nonce = golden_nonce; end
    if (work_done)    begin wd_n++; wd_c = cyc; wd_rdy = work_ready; end
    if (core_error)   begin ce_n++; ce_c = cyc; end
  end

  int n_chk = 0, n_fail = 0;
  int acc, ld0, gv0, wd0, ce0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ldn(input int i);
    return (ld_n.size() > i) ? ld_n[i] : 32'hDEAD_DEAD;
  endfunction
  function automatic int ldc(input int i);
    return (ld_c.size() > i) ? ld_c[i] : -1;
  endfunction

  task automatic wait_to(input int n);
    while (cyc < n) begin @(posedge clk); #2; end
  endtask

  // Presents one work unit for a single cycle; acc = the accepting cycle.
  task automatic start_job(input logic [31:0] s, input logic [31:0] e, input logic ab);
    int guard = 0;
    while (!work_ready && guard < 200) begin @(posedge clk); #2; guard++; end
    if (!work_ready) chk("ready_wait", 64'(work_ready), 64'd1);
    nonce_start = s; nonce_end = e; work_target = 64'h20;
    work_block = {16{32'hDEADBEEF}};
    work_midstate = {16{32'h0123_4567 + s}};
    ld0 = ld_n.size(); gv0 = gv_n; wd0 = wd_n; ce0 = ce_n;
    work_valid = 1'b1; abort = ab; acc = cyc;
    @(posedge clk); #2;
    work_valid = 1'b0; abort = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    chk("rst_ready",   64'(work_ready), 64'd1);
    chk("rst_busy",    64'(busy), 64'd0);
    chk("rst_core_rst", 64'(core_rst), 64'd1);
    chk("rst_block",   core_block[63:0], 64'd0);
    chk("rst_gnonce",  64'(golden_nonce), 64'd0);
    chk("rst_pulses",  {61'd0, golden_valid, work_done, core_error}, 64'd0);
    rst = 1'b0;
    @(posedge clk); #2;

    // single nonce, passing
    pass_n = 32'd5; hv_pass = 64'h10; hv_fail = 64'h30;
    start_job(32'd5, 32'd5, 1'b0);
    wait_to(acc + 30);
    chk("t1_loads",   64'(ld_n.size() - ld0), 64'd1);
    chk("t1_ldnonce", 64'(ldn(ld0)), 64'd5);
    chk("t1_ldcyc",   64'(ldc(ld0) - acc), 64'd1);
    chk("t1_blk_lo",  ld_blk[95:32], 64'hDEADBEEF_DEADBEEF);
    chk("t1_blk_hi",  ld_blk[511:448], 64'hDEADBEEF_DEADBEEF);
    chk("t1_state",   ld_st[63:0], {2{32'h0123_456C}});
    chk("t1_gv",      64'(gv_n - gv0), 64'd1);
    chk("t1_gnonce",  64'(gv_nonce), 64'd5);
    chk("t1_gv_cyc",  64'(gv_c - acc), 64'd23);
    chk("t1_wd",      64'(wd_n - wd0), 64'd1);
    chk("t1_wd_cyc",  64'(wd_c - acc), 64'd24);
    chk("t1_wd_rdy",  64'(wd_rdy), 64'd1);

    // four nonces, only 0x12 passes
    pass_n = 32'h12;
    start_job(32'h10, 32'h13, 1'b0);
    wait_to(acc + 95);
    chk("t2_loads", 64'(ld_n.size() - ld0), 64'd4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("t2_ldnonce%0d", k), 64'(ldn(ld0 + k)), 64'(32'h10 + k));
      chk($sformatf("t2_ldcyc%0d", k), 64'(ldc(ld0 + k) - acc), 64'(1 + 22 * k));
    end
    chk("t2_gv",     64'(gv_n - gv0), 64'd1);
    chk("t2_gnonce", 64'(gv_nonce), 64'h12);
    chk("t2_gv_cyc", 64'(gv_c - acc), 64'd67);
    chk("t2_wd",     64'(wd_n - wd0), 64'd1);
    chk("t2_wd_cyc", 64'(wd_c - acc), 64'd90);

    // wrapping range, hash one above target fails everywhere
    pass_n = 32'd5; hv_fail = 64'h21;
    start_job(32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
    wait_to(acc + 95);
    chk("t3_loads", 64'(ld_n.size() - ld0), 64'd4);
    chk("t3_n0", 64'(ldn(ld0)),     64'hFFFF_FFFE);
    chk("t3_n1", 64'(ldn(ld0 + 1)), 64'hFFFF_FFFF);
    chk("t3_n2", 64'(ldn(ld0 + 2)), 64'h0);
    chk("t3_n3", 64'(ldn(ld0 + 3)), 64'h1);
    chk("t3_gv", 64'(gv_n - gv0), 64'd0);
    chk("t3_wd_cyc", 64'(wd_c - acc), 64'd90);

    // hash equal to target passes; abort alongside work_valid in IDLE
    pass_n = 32'd7; hv_pass = 64'h20; hv_fail = 64'h30;
    start_job(32'd7, 32'd7, 1'b1);
    wait_to(acc + 30);
    chk("t4_loads",  64'(ld_n.size() - ld0), 64'd1);
    chk("t4_gv",     64'(gv_n - gv0), 64'd1);
    chk("t4_gnonce", 64'(gv_nonce), 64'd7);
    chk("t4_wd",     64'(wd_n - wd0), 64'd1);

    // core never answers: watchdog
    hang = 1'b1;
    start_job(32'd3, 32'd3, 1'b0);
    wait_to(acc + 70);
    chk("t5_ce",     64'(ce_n - ce0), 64'd1);
    chk("t5_ce_cyc", 64'(ce_c - acc), 64'd65);
    chk("t5_wd_cyc", 64'(wd_c - acc), 64'd66);
    chk("t5_wd_rdy", 64'(wd_rdy), 64'd1);
    chk("t5_gv",     64'(gv_n - gv0), 64'd0);
    hang = 1'b0;

    // abort in the CHECK cycle of a passing nonce
    pass_n = 32'd9; hv_pass = 64'h10;
    start_job(32'd9, 32'd9, 1'b0);
    wait_to(acc + 22);
    abort = 1'b1;
    @(posedge clk); #2;
    abort = 1'b0;
    chk("t6_busy",  64'(busy), 64'd0);
    chk("t6_crst",  64'(core_rst), 64'd1);
    chk("t6_ready", 64'(work_ready), 64'd1);
    wait_to(acc + 30);
    chk("t6_gv", 64'(gv_n - gv0), 64'd0);
    chk("t6_wd", 64'(wd_n - wd0), 64'd0);

    // reset mid-WAIT after an earlier find, then a stray ready pulse
    chk("t7_pre_gnonce", 64'(golden_nonce), 64'd7);
    start_job(32'h20, 32'h20, 1'b0);
    wait_to(acc + 10);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("t7_gnonce", 64'(golden_nonce), 64'd0);
    chk("t7_busy",   64'(busy), 64'd0);
    chk("t7_crst",   64'(core_rst), 64'd1);
    chk("t7_ready",  64'(work_ready), 64'd1);
    stray = 1'b1;
    @(posedge clk); #2;
    stray = 1'b0;
    repeat (30) begin @(posedge clk); #2; end
    chk("t7_gv", 64'(gv_n - gv0), 64'd0);
    chk("t7_wd", 64'(wd_n - wd0), 64'd0);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
